// File: rtl/cust_afu_axi_pkg.sv
// Shared AXI4-MM widths, response codes and the queued AR entry layout.
package cust_afu_axi_pkg;

  localparam int ADDR_W = 64;
  localparam int ID_W   = 12;
  localparam int USER_W = 6;
  localparam int DATA_W = 512;

  typedef enum logic [1:0] {OKAY, EXOKAY, SLVERR, DECERR} resp_e;

  // id already carries the channel index in its upper bits
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [USER_W-1:0] user;
    logic [ADDR_W-1:0] addr;
  } ar_entry_t;

endpackage

// File: rtl/ar_req_fifo.sv
// Synchronous AR request queue; head visible the cycle after push, pop frees an entry same cycle.
// Push is ignored when full, pop is ignored when empty.
module ar_req_fifo
  import cust_afu_axi_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  ar_entry_t i_push_dat,
  input  logic      i_pop,
  output ar_entry_t o_head_dat,
  output logic      o_full,
  output logic      o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  ar_entry_t   r_mem [DEPTH];

  // extra pointer bit distinguishes full from empty when the low bits match
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_push && !o_full) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (i_pop && !o_empty) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/read_arb_router.sv
// Shares one CXL AXI4-MM read port among CH AFU read masters: AR arbitrated into a queue, R routed back by rid.
// RR_ARB_EN selects round-robin arbitration; otherwise fixed priority (lowest index first).
module read_arb_router
  import cust_afu_axi_pkg::*;
#(
  parameter int CH      = 1,
  parameter int DEPTH   = 16,
  parameter int MAX_OUT = 8
) (
  input  logic                          axi4_mm_clk,
  input  logic                          axi4_mm_rst,
  input  logic [CH-1:0]                 arvalid_ch,
  output logic [CH-1:0]                 arready_ch,
  input  logic [CH-1:0][ID_W-1:0]       arid_ch,
  input  logic [CH-1:0][USER_W-1:0]     aruser_ch,
  input  logic [CH-1:0][ADDR_W-1:0]     araddr_ch,
  output logic [CH-1:0]                 rvalid_ch,
  input  logic [CH-1:0]                 rready_ch,
  output logic [CH-1:0][DATA_W-1:0]     rdata_ch,
  output logic [CH-1:0][ID_W-1:0]       rid_ch,
  output logic [CH-1:0][1:0]            rresp_ch,
  output logic [CH-1:0]                 rlast_ch,
  output logic                          arvalid,
  input  logic                          arready,
  output logic [ID_W-1:0]               arid,
  output logic [USER_W-1:0]             aruser,
  output logic [ADDR_W-1:0]             araddr,
  input  logic                          rvalid,
  output logic                          rready,
  input  logic [DATA_W-1:0]             rdata,
  input  logic [ID_W-1:0]               rid,
  input  logic [1:0]                    rresp,
  input  logic                          rlast
);

  localparam int CHW  = (CH > 1) ? $clog2(CH) : 1;
  localparam int IDW  = ID_W - CHW;
  localparam int CNTW = $clog2(MAX_OUT + 1);

  logic [CH-1:0][CNTW-1:0] r_out_cnt;
  logic [CH-1:0]           w_elig;
  logic                    w_gnt_vld;
  logic [CHW-1:0]          w_gnt_idx;
  logic                    w_push, w_pop, w_full, w_empty;
  ar_entry_t               w_push_ent, w_head;
  logic                    w_unused_arid_hi;

  assign w_unused_arid_hi = ^arid_ch;

  always_comb begin
    for (int i = 0; i < CH; i++) w_elig[i] = arvalid_ch[i] && (r_out_cnt[i] < CNTW'(MAX_OUT));
  end

`ifdef RR_ARB_EN
  // r_rr_ptr holds where the next search starts (last grant + 1)
  logic [CHW-1:0] r_rr_ptr;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = CHW'(i);
      end
    end
    for (int i = CH - 1; i >= 0; i--) begin
      if (w_elig[i] && (CHW'(i) >= r_rr_ptr)) w_gnt_idx = CHW'(i);
    end
  end

  always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
    if (axi4_mm_rst) r_rr_ptr <= '0;
    else if (w_push) r_rr_ptr <= (w_gnt_idx == CHW'(CH - 1)) ? '0 : w_gnt_idx + 1'b1;
  end
`else
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = CHW'(i);
      end
    end
  end
`endif

  assign w_push = w_gnt_vld && !w_full && !axi4_mm_rst;

  always_comb begin
    arready_ch = '0;
    w_push_ent = '0;
    for (int i = 0; i < CH; i++) begin
      if (w_gnt_idx == CHW'(i)) begin
        arready_ch[i]   = w_push;
        w_push_ent.id   = {CHW'(i), arid_ch[i][IDW-1:0]};
        w_push_ent.user = aruser_ch[i];
        w_push_ent.addr = araddr_ch[i];
      end
    end
  end

  ar_req_fifo #(.DEPTH(DEPTH)) u_ar_q (
    .clk        (axi4_mm_clk),
    .rst        (axi4_mm_rst),
    .i_push     (w_push),
    .i_push_dat (w_push_ent),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign arvalid = !w_empty;
  assign arid    = w_head.id;
  assign aruser  = w_head.user;
  assign araddr  = w_head.addr;
  assign w_pop   = arvalid && arready;

  logic              r_vld_q;
  logic [CHW-1:0]    r_dst_q;
  logic [IDW-1:0]    r_id_q;
  logic [DATA_W-1:0] r_data_q;
  resp_e             r_resp_q;
  logic              r_last_q;
  logic [CHW-1:0]    w_rid_ch;
  logic              w_rid_ok, w_dst_rdy, w_r_load;

  assign w_rid_ch = rid[ID_W-1:IDW];
  assign w_rid_ok = ({1'b0, w_rid_ch} < (CHW + 1)'(CH));

  always_comb begin
    w_dst_rdy = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (r_dst_q == CHW'(i)) w_dst_rdy = rready_ch[i];
    end
  end

  // drain and load can share a cycle, so the stage sustains one beat per clock
  assign rready   = !axi4_mm_rst && (!r_vld_q || w_dst_rdy);
  assign w_r_load = rvalid && rready && w_rid_ok;

  always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
    if (axi4_mm_rst) begin
      r_vld_q  <= 1'b0;
      r_dst_q  <= '0;
      r_id_q   <= '0;
      r_data_q <= '0;
      r_resp_q <= OKAY;
      r_last_q <= 1'b0;
    end else if (w_r_load) begin
      r_vld_q  <= 1'b1;
      r_dst_q  <= w_rid_ch;
      r_id_q   <= rid[IDW-1:0];
      r_data_q <= rdata;
      r_resp_q <= resp_e'(rresp);
      r_last_q <= rlast;
    end else if (w_dst_rdy) begin
      r_vld_q  <= 1'b0;
    end
  end

  // saturating at zero lets late beats after a reset complete harmlessly
  always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
    if (axi4_mm_rst) begin
      r_out_cnt <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if ((w_push && (w_gnt_idx == CHW'(i))) && !(w_r_load && rlast && (w_rid_ch == CHW'(i))))
          r_out_cnt[i] <= r_out_cnt[i] + 1'b1;
        else if (!(w_push && (w_gnt_idx == CHW'(i))) && (w_r_load && rlast && (w_rid_ch == CHW'(i)))
                 && (r_out_cnt[i] != '0))
          r_out_cnt[i] <= r_out_cnt[i] - 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      rvalid_ch[i] = r_vld_q && (r_dst_q == CHW'(i));
      rdata_ch[i]  = r_data_q;
      rid_ch[i]    = {{CHW{1'b0}}, r_id_q};
      rresp_ch[i]  = r_resp_q;
      rlast_ch[i]  = r_last_q;
    end
  end

endmodule

// File: tb/tb_read_arb_router.sv
// Directed self-checking bench for read_arb_router with CH=4, DEPTH=16, MAX_OUT=8.
module tb_read_arb_router;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           arvalid_ch, arready_ch, rvalid_ch, rready_ch, rlast_ch;
  logic [3:0][11:0]     arid_ch, rid_ch;
  logic [3:0][5:0]      aruser_ch;
  logic [3:0][63:0]     araddr_ch;
  logic [3:0][511:0]    rdata_ch;
  logic [3:0][1:0]      rresp_ch;
  logic                 arvalid, arready, rvalid, rready, rlast;
  logic [11:0]          arid, rid;
  logic [5:0]           aruser;
  logic [63:0]          araddr;
  logic [511:0]         rdata;
  logic [1:0]           rresp;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  read_arb_router #(.CH(4), .DEPTH(16), .MAX_OUT(8)) dut (
    .axi4_mm_clk(clk), .axi4_mm_rst(rst),
    .arvalid_ch(arvalid_ch), .arready_ch(arready_ch), .arid_ch(arid_ch),
    .aruser_ch(aruser_ch), .araddr_ch(araddr_ch),
    .rvalid_ch(rvalid_ch), .rready_ch(rready_ch), .rdata_ch(rdata_ch),
    .rid_ch(rid_ch), .rresp_ch(rresp_ch), .rlast_ch(rlast_ch),
    .arvalid(arvalid), .arready(arready), .arid(arid), .aruser(aruser), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    arvalid_ch = '0; arid_ch = '0; aruser_ch = '0; araddr_ch = '0;
    rready_ch = 4'hF; arready = 1'b0;
    rvalid = 1'b0; rdata = '0; rid = '0; rresp = '0; rlast = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    arvalid_ch = 4'hF;
    rvalid = 1'b1;
    repeat (2) cyc();
    tests++; if (arready_ch !== 4'h0) begin fails++; $display("FAIL reset_arready_ch: got %h want 0", arready_ch); end
    tests++; if (rready !== 1'b0) begin fails++; $display("FAIL reset_rready: got %b want 0", rready); end
    tests++; if (arvalid !== 1'b0) begin fails++; $display("FAIL reset_arvalid: got %b want 0", arvalid); end
    tests++; if (rvalid_ch !== 4'h0) begin fails++; $display("FAIL reset_rvalid_ch: got %h want 0", rvalid_ch); end
    tests++; if (araddr !== 64'h0 || arid !== 12'h0) begin fails++; $display("FAIL reset_ar_payload: got %h/%h want 0/0", arid, araddr); end
    tests++; if (rdata_ch[1] !== 512'h0) begin fails++; $display("FAIL reset_rdata: got nonzero %h want 0", rdata_ch[1]); end
    idle();
    rst = 1'b0;
    cyc();
    tests++; if (rready !== 1'b1) begin fails++; $display("FAIL post_reset_rready: got %b want 1", rready); end
  endtask

  task automatic test_single();
    logic [511:0] d;
    do_reset();
    d = {16{32'hA5A5_0001}};
    arvalid_ch = 4'b0100; arid_ch[2] = 12'h005; araddr_ch[2] = 64'h1000; aruser_ch[2] = 6'h03;
    #1;
    tests++; if (arready_ch !== 4'b0100) begin fails++; $display("FAIL single_arready: got %b want 0100", arready_ch); end
    tests++; if (arvalid !== 1'b0) begin fails++; $display("FAIL single_arvalid_early: got %b want 0", arvalid); end
    cyc();
    arvalid_ch = '0;
    #1;
    tests++; if ({arvalid, arid, aruser, araddr} !== {1'b1, 12'h805, 6'h03, 64'h1000})
      begin fails++; $display("FAIL single_cxl_ar: got v=%b id=%h u=%h a=%h want v=1 id=805 u=03 a=1000", arvalid, arid, aruser, araddr); end
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    #1;
    tests++; if (arvalid !== 1'b0) begin fails++; $display("FAIL single_pop: got arvalid=%b want 0", arvalid); end
    rvalid = 1'b1; rid = 12'h805; rdata = d; rresp = 2'd2; rlast = 1'b1;
    #1;
    tests++; if (rready !== 1'b1) begin fails++; $display("FAIL single_rready: got %b want 1", rready); end
    cyc();
    rvalid = 1'b0;
    #1;
    tests++; if (rvalid_ch !== 4'b0100) begin fails++; $display("FAIL single_rvalid_ch: got %b want 0100", rvalid_ch); end
    tests++; if ({rid_ch[2], rresp_ch[2], rlast_ch[2]} !== {12'h005, 2'd2, 1'b1})
      begin fails++; $display("FAIL single_r_meta: got id=%h resp=%0d last=%b want 005/2/1", rid_ch[2], rresp_ch[2], rlast_ch[2]); end
    tests++; if (rdata_ch[2] !== d) begin fails++; $display("FAIL single_rdata: got %h want %h", rdata_ch[2], d); end
    cyc();
    tests++; if (rvalid_ch !== 4'b0000) begin fails++; $display("FAIL single_r_drain: got %b want 0000", rvalid_ch); end
  endtask

  task automatic test_arbitration();
    logic [3:0]  exp_gnt;
    logic [11:0] exp_id;
    int          prev;
    do_reset();
    arready = 1'b1;
    prev = 0;
    for (int c = 0; c < 8; c++) begin
      arvalid_ch = 4'hF;
      for (int i = 0; i < 4; i++) arid_ch[i] = 12'(i);
`ifdef RR_ARB_EN
      exp_gnt = 4'b0001 << (c % 4);
`else
      exp_gnt = 4'b0001;
`endif
      #1;
      tests++; if (arready_ch !== exp_gnt) begin fails++; $display("FAIL arb_grant_%0d: got %b want %b", c, arready_ch, exp_gnt); end
      if (c > 0) begin
        exp_id = 12'((prev << 10) | prev);
        tests++; if (arvalid !== 1'b1 || arid !== exp_id) begin fails++; $display("FAIL arb_arid_%0d: got v=%b id=%h want v=1 id=%h", c, arvalid, arid, exp_id); end
      end
`ifdef RR_ARB_EN
      prev = c % 4;
`else
      prev = 0;
`endif
      cyc();
    end
    arvalid_ch = '0;
  endtask

  task automatic test_full_drain();
    logic [3:0]  exp_gnt;
    logic [81:0] exp_ent;
    int          ch;
    do_reset();
    for (int k = 0; k < 17; k++) begin
      ch = k % 4;
      arvalid_ch = 4'b0001 << ch;
      arid_ch[ch] = 12'hC00 | 12'(k);
      aruser_ch[ch] = 6'(k);
      araddr_ch[ch] = 64'h1000_0000 + 64'(k * 64);
      exp_gnt = (k < 16) ? (4'b0001 << ch) : 4'b0000;
      #1;
      tests++; if (arready_ch !== exp_gnt) begin fails++; $display("FAIL full_accept_%0d: got %b want %b", k, arready_ch, exp_gnt); end
      cyc();
    end
    arvalid_ch = '0;
    arready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      exp_ent = {2'(k % 4), 10'(k), 6'(k), 64'h1000_0000 + 64'(k * 64)};
      #1;
      tests++; if (arvalid !== 1'b1 || {arid, aruser, araddr} !== exp_ent)
        begin fails++; $display("FAIL drain_%0d: got v=%b ent=%h want v=1 ent=%h", k, arvalid, {arid, aruser, araddr}, exp_ent); end
      cyc();
    end
    arready = 1'b0;
    #1;
    tests++; if (arvalid !== 1'b0) begin fails++; $display("FAIL drain_empty: got arvalid=%b want 0", arvalid); end
  endtask

  task automatic test_max_outstanding();
    do_reset();
    arready = 1'b1;
    arvalid_ch = 4'b0010;
    arid_ch[1] = 12'h011;
    for (int k = 0; k < 8; k++) begin
      #1;
      tests++; if (arready_ch !== 4'b0010) begin fails++; $display("FAIL maxout_accept_%0d: got %b want 0010", k, arready_ch); end
      cyc();
    end
    #1;
    tests++; if (arready_ch !== 4'b0000) begin fails++; $display("FAIL maxout_stall: got %b want 0000", arready_ch); end
    rvalid = 1'b1; rid = 12'h411; rlast = 1'b0;
    cyc();
    rvalid = 1'b0;
    #1;
    tests++; if (arready_ch !== 4'b0000 || rvalid_ch !== 4'b0010)
      begin fails++; $display("FAIL maxout_nonlast: got arready=%b rvalid=%b want 0000/0010", arready_ch, rvalid_ch); end
    cyc();
    rvalid = 1'b1; rid = 12'h411; rlast = 1'b1;
    cyc();
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    tests++; if (arready_ch !== 4'b0010) begin fails++; $display("FAIL maxout_release: got %b want 0010", arready_ch); end
    cyc();
    #1;
    tests++; if (arready_ch !== 4'b0000) begin fails++; $display("FAIL maxout_restall: got %b want 0000", arready_ch); end
    arvalid_ch = '0;
  endtask

  task automatic test_back_to_back();
    logic [511:0] da, db, dc;
    da = {16{32'h1111_0000}}; db = {16{32'h2222_0000}}; dc = {16{32'h3333_0000}};
    do_reset();
    rready_ch = 4'b0111;
    rvalid = 1'b1; rlast = 1'b1; rid = 12'h001; rdata = da;
    #1;
    tests++; if (rready !== 1'b1) begin fails++; $display("FAIL b2b_rready_a: got %b want 1", rready); end
    cyc();
    rid = 12'hC02; rdata = db;
    #1;
    tests++; if (rvalid_ch !== 4'b0001 || rdata_ch[0] !== da || rready !== 1'b1)
      begin fails++; $display("FAIL b2b_beat_a: got v=%b rdy=%b d=%h want v=0001 rdy=1", rvalid_ch, rready, rdata_ch[0][31:0]); end
    cyc();
    rid = 12'h003; rdata = dc;
    #1;
    tests++; if (rvalid_ch !== 4'b1000 || rdata_ch[3] !== db || rready !== 1'b0)
      begin fails++; $display("FAIL b2b_beat_b: got v=%b rdy=%b d=%h want v=1000 rdy=0 d=22220000", rvalid_ch, rready, rdata_ch[3][31:0]); end
    cyc();
    tests++; if (rvalid_ch !== 4'b1000 || rdata_ch[3] !== db || rready !== 1'b0)
      begin fails++; $display("FAIL b2b_hold: got v=%b rdy=%b want v=1000 rdy=0", rvalid_ch, rready); end
    rready_ch = 4'hF;
    #1;
    tests++; if (rready !== 1'b1) begin fails++; $display("FAIL b2b_rready_resume: got %b want 1", rready); end
    cyc();
    rvalid = 1'b0;
    #1;
    tests++; if (rvalid_ch !== 4'b0001 || rdata_ch[0] !== dc || rid_ch[0] !== 12'h003)
      begin fails++; $display("FAIL b2b_beat_c: got v=%b id=%h d=%h want v=0001 id=003 d=33330000", rvalid_ch, rid_ch[0], rdata_ch[0][31:0]); end
    cyc();
    tests++; if (rvalid_ch !== 4'b0000) begin fails++; $display("FAIL b2b_drain: got %b want 0000", rvalid_ch); end
  endtask

  task automatic test_reset_mid();
    int ch;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      ch = (k < 2) ? 2 : 1;
      arvalid_ch = 4'b0001 << ch;
      arid_ch[ch] = 12'(k);
      cyc();
    end
    arvalid_ch = '0;
    #1;
    tests++; if (arvalid !== 1'b1) begin fails++; $display("FAIL midrst_queued: got arvalid=%b want 1", arvalid); end
    rst = 1'b1;
    #1;
    tests++; if (arvalid !== 1'b0) begin fails++; $display("FAIL midrst_async: got arvalid=%b want 0", arvalid); end
    cyc();
    rst = 1'b0;
    cyc();
    tests++; if (arvalid !== 1'b0) begin fails++; $display("FAIL midrst_after: got arvalid=%b want 0", arvalid); end
    rvalid = 1'b1; rid = 12'h807; rlast = 1'b1;
    cyc();
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    tests++; if (rvalid_ch !== 4'b0100 || rid_ch[2] !== 12'h007)
      begin fails++; $display("FAIL midrst_late_beat: got v=%b id=%h want v=0100 id=007", rvalid_ch, rid_ch[2]); end
    arvalid_ch = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      #1;
      tests++; if (arready_ch !== 4'b0100) begin fails++; $display("FAIL midrst_cnt_%0d: got %b want 0100", k, arready_ch); end
      cyc();
    end
    #1;
    tests++; if (arready_ch !== 4'b0000) begin fails++; $display("FAIL midrst_cnt_limit: got %b want 0000", arready_ch); end
    arvalid_ch = '0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_single();
    test_arbitration();
    test_full_drain();
    test_max_outstanding();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
